// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared TDM link types and default geometry
package tdm_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tdm_state_t;

  // Shared with the transmit-side mux so both ends agree on frame shape
  localparam int TDM_N_CH = 4;
  localparam int TDM_W    = 8;

endpackage

// File: rtl/tdm_slot_decoder.sv
// rtl/tdm_slot_decoder.sv - enable-gated slot index to one-hot channel write strobe
module tdm_slot_decoder
  import tdm_pkg::*;
#(
  parameter int N_CH   = TDM_N_CH,
  parameter int SLOT_W = $clog2(TDM_N_CH)
) (
  input  logic              i_en,
  input  logic [SLOT_W-1:0] i_slot,
  output logic [N_CH-1:0]   o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (i_en && (i_slot == SLOT_W'(k))) begin
        o_onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM receive demux: routes frame words to per-channel registers
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = TDM_N_CH,
  parameter int W    = TDM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked
);

  localparam int SLOT_W = $clog2(N_CH);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CH - 1);

  tdm_state_t          r_state;
  logic [SLOT_W-1:0]   r_slot;
  logic [N_CH*W-1:0]   r_ch_data;
  logic [N_CH-1:0]     r_ch_valid;
  logic                r_frame_done;
  logic                r_sync_err;
  logic                r_locked;

  logic                w_cap_en;
  logic                w_early;
  logic                w_missing;
  logic [SLOT_W-1:0]   w_cap_slot;
  logic [N_CH-1:0]     w_we;

  // A sync word always lands in slot 0, even mid-frame; an unsynced word at slot 0 loses lock
  always_comb begin
    w_cap_en   = 1'b0;
    w_early    = 1'b0;
    w_missing  = 1'b0;
    w_cap_slot = frame_sync ? '0 : r_slot;
    if (din_valid) begin
      if (frame_sync) begin
        w_cap_en = 1'b1;
        w_early  = (r_state == ST_RUN) && (r_slot != '0);
      end else if (r_state == ST_RUN) begin
        if (r_slot == '0) w_missing = 1'b1;
        else              w_cap_en  = 1'b1;
      end
    end
  end

  tdm_slot_decoder #(
    .N_CH   (N_CH),
    .SLOT_W (SLOT_W)
  ) u_slot_decoder (
    .i_en     (w_cap_en),
    .i_slot   (w_cap_slot),
    .o_onehot (w_we)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_slot       <= '0;
      r_ch_data    <= '0;
      r_ch_valid   <= '0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_ch_valid   <= w_we;
      r_sync_err   <= w_early | w_missing;
      r_frame_done <= w_cap_en && !frame_sync && (r_slot == LAST_SLOT);
      for (int k = 0; k < N_CH; k++) begin
        if (w_we[k]) r_ch_data[k*W +: W] <= din;
      end
      if (w_cap_en) begin
        r_state  <= ST_RUN;
        r_locked <= 1'b1;
        if (frame_sync)               r_slot <= SLOT_W'(1);
        else if (r_slot == LAST_SLOT) r_slot <= '0;
        else                          r_slot <= r_slot + SLOT_W'(1);
      end else if (w_missing) begin
        r_state  <= ST_IDLE;
        r_locked <= 1'b0;
        r_slot   <= '0;
      end
    end
  end

  assign ch_data    = r_ch_data;
  assign ch_valid   = r_ch_valid;
  assign frame_done = r_frame_done;
  assign sync_err   = r_sync_err;
  assign locked     = r_locked;

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - self-checking bench for tdm_demux against a frame-level model
module tb_tdm_demux;

  localparam int N_CH = 4;
  localparam int W    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [W-1:0]      din;
  logic              din_valid;
  logic              frame_sync;
  logic [N_CH*W-1:0] ch_data;
  logic [N_CH-1:0]   ch_valid;
  logic              frame_done;
  logic              sync_err;
  logic              locked;

  int errors = 0;
  int checks = 0;
  int seen_err = 0;

  logic [W-1:0] m_data [N_CH];
  int           m_pos;
  bit           m_locked;
  int           m_wr;
  bit           m_done;
  bit           m_err;

  always #5 clk = ~clk;

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    m_wr   = -1;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (r) begin
      for (int k = 0; k < N_CH; k++) m_data[k] = '0;
      m_pos    = 0;
      m_locked = 1'b0;
    end else if (v) begin
      if (s) begin
        if (m_locked && m_pos != 0) m_err = 1'b1;
        m_wr     = 0;
        m_pos    = 1;
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (m_pos == 0) begin
          m_err    = 1'b1;
          m_locked = 1'b0;
        end else begin
          m_wr = m_pos;
          if (m_pos == N_CH - 1) begin
            m_done = 1'b1;
            m_pos  = 0;
          end else begin
            m_pos = m_pos + 1;
          end
        end
      end
      if (m_wr >= 0) m_data[m_wr] = d;
    end
  endtask

  task automatic step(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    logic [N_CH*W-1:0] e_data;
    logic [N_CH-1:0]   e_valid;
    rst        = r;
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    #1;
    model(r, v, s, d);
    for (int k = 0; k < N_CH; k++) e_data[k*W +: W] = m_data[k];
    e_valid = '0;
    if (m_wr >= 0) e_valid[m_wr] = 1'b1;
    if (sync_err) seen_err++;
    check("ch_data",    64'(ch_data),    64'(e_data));
    check("ch_valid",   64'(ch_valid),   64'(e_valid));
    check("frame_done", 64'(frame_done), 64'(m_done));
    check("sync_err",   64'(sync_err),   64'(m_err));
    check("locked",     64'(locked),     64'(m_locked));
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
    for (int k = 0; k < N_CH; k++) m_data[k] = '0;
    m_pos = 0; m_locked = 1'b0;

    // reset then clean frame
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    check("rst_data", 64'(ch_data), 64'h0);
    check("rst_locked", 64'(locked), 64'h0);
    step(0, 1, 1, 8'h11);
    check("clean_v0", 64'(ch_valid), 64'h1);
    check("clean_lock", 64'(locked), 64'h1);
    step(0, 1, 0, 8'h22);
    check("clean_v1", 64'(ch_valid), 64'h2);
    step(0, 1, 0, 8'h33);
    check("clean_v2", 64'(ch_valid), 64'h4);
    step(0, 1, 0, 8'h44);
    check("clean_v3", 64'(ch_valid), 64'h8);
    check("clean_done", 64'(frame_done), 64'h1);
    check("clean_data", 64'(ch_data), 64'h44332211);

    // gapped frame, sync asserted during an idle cycle
    step(0, 1, 1, 8'h11);
    for (int i = 0; i < 3; i++) step(0, 0, (i == 1), 8'hEE);
    step(0, 1, 0, 8'h22);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'hEE);
    step(0, 1, 0, 8'h33);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 8'hEE);
    step(0, 1, 0, 8'h44);
    check("gap_data", 64'(ch_data), 64'h44332211);
    check("gap_done", 64'(frame_done), 64'h1);

    // pre-sync garbage
    step(1, 0, 0, 8'h00);
    seen_err = 0;
    step(0, 1, 0, 8'hAA);
    check("garbage_drop", 64'(ch_valid), 64'h0);
    step(0, 1, 0, 8'hBB);
    step(0, 1, 1, 8'h01);
    step(0, 1, 0, 8'h02);
    step(0, 1, 0, 8'h03);
    step(0, 1, 0, 8'h04);
    check("garbage_data", 64'(ch_data), 64'h04030201);
    check("garbage_noerr", 64'(seen_err), 64'h0);

    // early sync
    step(0, 1, 1, 8'h11);
    step(0, 1, 0, 8'h22);
    step(0, 1, 1, 8'h55);
    check("early_err", 64'(sync_err), 64'h1);
    check("early_nodone", 64'(frame_done), 64'h0);
    check("early_v0", 64'(ch_valid), 64'h1);
    step(0, 1, 0, 8'h66);
    step(0, 1, 0, 8'h77);
    step(0, 1, 0, 8'h88);
    check("early_data", 64'(ch_data), 64'h88776655);
    check("early_done", 64'(frame_done), 64'h1);

    // missing sync and relock
    step(0, 1, 1, 8'hA1);
    step(0, 1, 0, 8'hA2);
    step(0, 1, 0, 8'hA3);
    step(0, 1, 0, 8'hA4);
    step(0, 1, 0, 8'h99);
    check("miss_err", 64'(sync_err), 64'h1);
    check("miss_unlock", 64'(locked), 64'h0);
    check("miss_nocap", 64'(ch_data), 64'hA4A3A2A1);
    step(0, 1, 1, 8'h10);
    check("relock_v0", 64'(ch_valid), 64'h1);
    check("relock", 64'(locked), 64'h1);

    // reset mid-frame
    step(0, 1, 0, 8'h20);
    step(0, 1, 0, 8'h30);
    step(1, 1, 0, 8'h40);
    check("midrst_data", 64'(ch_data), 64'h0);
    check("midrst_flags", 64'({ch_valid, frame_done, sync_err, locked}), 64'h0);
    step(0, 1, 0, 8'h50);
    check("midrst_drop", 64'(ch_valid), 64'h0);
    step(0, 1, 1, 8'h60);
    check("midrst_restart", 64'(ch_data), 64'h00000060);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0), W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
